get_trig_vals_lut_reader: RTL and testbench
===========================================

GET_TRIG_VALS_LUT_READER -- requirements
Module: get_trig_vals_lut_reader

Interface
REQ-001 SHALL have parameter PWIDTH, default 10, meaning the phase input width (2 quadrant MSBs plus AWIDTH index bits).
REQ-002 SHALL have parameter AWIDTH, default 8, meaning the quarter-wave table address width (PWIDTH-2).
REQ-003 SHALL have parameter DWIDTH, default 16, meaning the unsigned table word width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port phase_in, input, PWIDTH bits: unsigned phase, where full scale is 2*pi.
REQ-007 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the phase handshake.
REQ-008 SHALL have ports addr0 (output, AWIDTH bits), ce0 (output, 1 bit) and q0 (input, DWIDTH bits): ROM port 0, used for sine.
REQ-009 SHALL have ports addr1 (output, AWIDTH bits), ce1 (output, 1 bit) and q1 (input, DWIDTH bits): ROM port 1, used for cosine.
REQ-010 SHALL have ports sin_out and cos_out, output, DWIDTH+1 bits each: two's-complement results.
REQ-011 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the result handshake.

Function
REQ-012 SHALL treat the ROM as holding T[k] = round((2^DWIDTH-1)*sin(k*pi/2^(AWIDTH+1))) for k = 0..2^AWIDTH-1, with q registered one cycle after ce high and held while ce is low.
REQ-013 SHALL split the phase as quadrant Q = phase_in[PWIDTH-1:PWIDTH-2] and index i = phase_in[AWIDTH-1:0].
REQ-014 SHALL define lookup(q, i) as follows:
- q=0: +T[i]
- q=1: +T[2^AWIDTH-i], or +MAX when i=0
- q=2: -T[i]
- q=3: -T[2^AWIDTH-i], or -MAX when i=0
- MAX = 2^DWIDTH-1
REQ-015 SHALL compute sin_out = lookup(Q, i) and cos_out = lookup((Q+1) mod 4, i).
REQ-016 SHALL drive addr0 to 0 when the full-scale override applies; the override flag and sign SHALL travel in a side pipeline aligned with the ROM latency.
REQ-017 SHALL form the pipeline from three parts:
- stage A: accept and drive addr/ce
- stage B: ROM data valid (v1 plus sideband)
- stage C: registered outputs (out_valid)
REQ-018 SHALL compute a global enable en = ~out_valid | out_ready; in_ready SHALL equal en (combinational), and every stage SHALL advance only when en=1.
REQ-019 SHALL drive ce0 = ce1 = en & in_valid; the ROM SHALL never be enabled while stalled, so q0/q1 hold.
REQ-020 SHALL have a latency of exactly 2 cycles from an accepted beat (in_valid & in_ready) to the matching out_valid, when unstalled.
REQ-021 SHALL sustain a throughput of one result per cycle when out_ready is held at 1.
REQ-022 SHALL hold sin_out/cos_out/out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL accept a new beat on the same cycle a result is consumed (simultaneous in and out handshake) with no bubble.
REQ-024 SHALL negate as the two's complement of the zero-extended DWIDTH+1-bit magnitude; -0 SHALL yield 0.

Reset
REQ-025 SHALL, on reset assertion, clear v1 and out_valid and drive sin_out=0, cos_out=0 and all sideband registers to 0, asynchronously.
REQ-026 SHALL drive ce0=ce1=0 and addr0=addr1=0 while reset is high.
REQ-027 SHALL discard any beats in flight when reset is asserted mid-operation; the first post-reset result SHALL come from a post-reset input.

Structure
REQ-028 SHALL place the quadrant encoding constants and the MAX-derivation function in shared package trig_lut_pkg.
REQ-029 SHALL use one sub-module, trig_quadrant_map, for the combinational (Q, i) -> {addr, negate, override} mapping, instantiated twice (sine and cosine).
REQ-030 SHALL be 120-400 lines of RTL with no internal table storage.

Verification
REQ-031 SHALL use a bench ROM model with T[k]=k*256 and DWIDTH=16, AWIDTH=8.
REQ-032 SHALL verify: phase 0x000 -> sin_out=0, cos_out=+65535, with out_valid exactly 2 cycles after acceptance.
REQ-033 SHALL verify: phase 0x140 (Q=1, i=0x40) -> sin_out=+T[192]=49152, cos_out=-T[64]=-16384.
REQ-034 SHALL verify: phase 0x300 -> sin_out=-65535, cos_out=0; phase 0x200 -> sin_out=0, cos_out=-65535.
REQ-035 SHALL verify: 8 back-to-back phases with out_ready=1 -> 8 results on consecutive cycles, in order; then out_ready=0 for 5 cycles -> in_ready=0, ce0=ce1=0, and outputs frozen; on release, no loss or duplication.
REQ-036 SHALL verify: reset pulsed with 2 beats in flight -> out_valid=0 immediately; the next result corresponds to the first post-reset input only.

Source files
------------

// File: rtl/trig_lut_pkg.sv
// Shared quadrant encoding and full-scale helper for the quarter-wave trig LUT reader.
package trig_lut_pkg;

  typedef enum logic [1:0] {
    QUAD_I   = 2'd0,
    QUAD_II  = 2'd1,
    QUAD_III = 2'd2,
    QUAD_IV  = 2'd3
  } quad_e;

  // Per-lookup sideband that rides alongside the ROM read.
  typedef struct packed {
    logic neg;
    logic ovr;
  } side_t;

  function automatic logic [63:0] full_scale(input int unsigned dwidth);
    return (64'd1 << dwidth) - 64'd1;
  endfunction

  // Cosine is sine advanced by one quadrant.
  function automatic logic [1:0] cos_quad(input logic [1:0] q);
    return q + 2'd1;
  endfunction

endpackage

// File: rtl/trig_quadrant_map.sv
// Maps (quadrant, index) onto a quarter-wave ROM address plus sign and full-scale override.
module trig_quadrant_map
  import trig_lut_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic [1:0]        i_quad,
  input  logic [AWIDTH-1:0] i_idx,
  output logic [AWIDTH-1:0] o_addr,
  output side_t             o_side
);

  logic [AWIDTH-1:0] w_mirror;
  logic              w_idx_zero;

  // 2^AWIDTH - i, modulo the table size; the i=0 case is handled by the override.
  assign w_mirror   = ~i_idx + AWIDTH'(1);
  assign w_idx_zero = (i_idx == '0);

  always_comb begin
    o_addr     = i_idx;
    o_side.neg = 1'b0;
    o_side.ovr = 1'b0;
    case (quad_e'(i_quad))
      QUAD_I: begin
        o_addr = i_idx;
      end
      QUAD_II: begin
        o_side.ovr = w_idx_zero;
        o_addr     = w_idx_zero ? '0 : w_mirror;
      end
      QUAD_III: begin
        o_side.neg = 1'b1;
        o_addr     = i_idx;
      end
      QUAD_IV: begin
        o_side.neg = 1'b1;
        o_side.ovr = w_idx_zero;
        o_addr     = w_idx_zero ? '0 : w_mirror;
      end
      default: begin
        o_addr = i_idx;
      end
    endcase
  end

endmodule

// File: rtl/get_trig_vals_lut_reader.sv
// Sine/cosine reader over an external dual-port quarter-wave ROM; 2-cycle latency, global-stall pipeline.
module get_trig_vals_lut_reader
  import trig_lut_pkg::*;
#(
  parameter int PWIDTH = 10,
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PWIDTH-1:0] phase_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [AWIDTH-1:0] addr0,
  output logic              ce0,
  input  logic [DWIDTH-1:0] q0,
  output logic [AWIDTH-1:0] addr1,
  output logic              ce1,
  input  logic [DWIDTH-1:0] q1,
  output logic [DWIDTH:0]   sin_out,
  output logic [DWIDTH:0]   cos_out,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [DWIDTH-1:0] MAX = DWIDTH'(full_scale(DWIDTH));

  logic              w_en;
  logic              w_ce;
  logic [1:0]        w_quad_s;
  logic [1:0]        w_quad_c;
  logic [AWIDTH-1:0] w_idx;
  logic [AWIDTH-1:0] w_addr_s;
  logic [AWIDTH-1:0] w_addr_c;
  side_t             w_side_s;
  side_t             w_side_c;

  logic              r_v1;
  side_t             r_side_s;
  side_t             r_side_c;
  logic              r_out_valid;
  logic [DWIDTH:0]   r_sin;
  logic [DWIDTH:0]   r_cos;

  // Single enable for every stage: the output slot is free or being drained.
  assign w_en     = ~r_out_valid | out_ready;
  assign in_ready = w_en;
  assign w_ce     = w_en & in_valid & ~reset;

  assign w_quad_s = phase_in[PWIDTH-1 -: 2];
  assign w_quad_c = cos_quad(w_quad_s);
  assign w_idx    = phase_in[AWIDTH-1:0];

  trig_quadrant_map #(.AWIDTH(AWIDTH)) u_map_sin (
    .i_quad (w_quad_s),
    .i_idx  (w_idx),
    .o_addr (w_addr_s),
    .o_side (w_side_s)
  );

  trig_quadrant_map #(.AWIDTH(AWIDTH)) u_map_cos (
    .i_quad (w_quad_c),
    .i_idx  (w_idx),
    .o_addr (w_addr_c),
    .o_side (w_side_c)
  );

  // Stage A: ROM request.
  assign ce0   = w_ce;
  assign ce1   = w_ce;
  assign addr0 = reset ? '0 : w_addr_s;
  assign addr1 = reset ? '0 : w_addr_c;

  function automatic logic [DWIDTH:0] apply_sign(input logic [DWIDTH-1:0] q, input side_t s);
    logic [DWIDTH:0] ext;
    ext = {1'b0, (s.ovr ? MAX : q)};
    return s.neg ? -ext : ext;
  endfunction

  // Stage B: ROM data lands; sideband tracks it so both leave the ROM cycle together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1     <= 1'b0;
      r_side_s <= '0;
      r_side_c <= '0;
    end else if (w_en) begin
      r_v1     <= in_valid;
      r_side_s <= w_side_s;
      r_side_c <= w_side_c;
    end
  end

  // Stage C: signed results held until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_sin       <= '0;
      r_cos       <= '0;
    end else if (w_en) begin
      r_out_valid <= r_v1;
      r_sin       <= apply_sign(q0, r_side_s);
      r_cos       <= apply_sign(q1, r_side_c);
    end
  end

  assign out_valid = r_out_valid;
  assign sin_out   = r_sin;
  assign cos_out   = r_cos;

endmodule

// File: tb/tb_get_trig_vals_lut_reader.sv
// Scoreboard bench for get_trig_vals_lut_reader with a T[k]=k*256 ROM model.
module tb_get_trig_vals_lut_reader;

  localparam int PW = 10;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] phase_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] addr0, addr1;
  logic          ce0, ce1;
  logic [DW-1:0] q0 = '0;
  logic [DW-1:0] q1 = '0;
  logic [DW:0]   sin_out, cos_out;
  logic          out_valid;
  logic          out_ready = 1'b1;

  get_trig_vals_lut_reader #(.PWIDTH(PW), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .phase_in(phase_in), .in_valid(in_valid), .in_ready(in_ready),
    .addr0(addr0), .ce0(ce0), .q0(q0), .addr1(addr1), .ce1(ce1), .q1(q1),
    .sin_out(sin_out), .cos_out(cos_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ce0) q0 <= {addr0, 8'h00};
    if (ce1) q1 <= {addr1, 8'h00};
  end

  typedef struct { int s; int c; int acc; bit lat; } exp_t;
  typedef struct { logic [PW-1:0] ph; int s; int c; } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[8];
  int   n_pass = 0, n_chk = 0;
  int   cyc = 0, n_out = 0, n_out0;
  int   nxt_s = 0, nxt_c = 0;
  bit   lat_en = 1'b0;
  logic acc;
  int   idx, stall_left;

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic int lut(input int q, input int i);
    int m;
    if (q % 2 == 1) m = (i == 0) ? 65535 : (256 - i) * 256;
    else            m = i * 256;
    return (q >= 2) ? -m : m;
  endfunction

  task automatic set_phase(input logic [PW-1:0] ph);
    phase_in = ph;
    nxt_s    = lut(int'(ph[9:8]), int'(ph[7:0]));
    nxt_c    = lut((int'(ph[9:8]) + 1) % 4, int'(ph[7:0]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    check(nm, sb.size(), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pops happen where the DUT presents a consumed result; pushes where a beat is accepted.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("unexpected_out", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("sin_out", int'($signed(sin_out)), mon_e.s);
          check("cos_out", int'($signed(cos_out)), mon_e.c);
          if (mon_e.lat) check("latency", cyc - mon_e.acc, 2);
        end
      end
      if (in_valid && in_ready) sb.push_back('{nxt_s, nxt_c, cyc, lat_en});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{10'h000,      0,  65535};
    vt[1] = '{10'h140,  49152, -16384};
    vt[2] = '{10'h300, -65535,      0};
    vt[3] = '{10'h200,      0, -65535};
    vt[4] = '{10'h100,  65535,      0};
    vt[5] = '{10'h040,  16384,  49152};
    vt[6] = '{10'h3FF,   -256,  65280};
    vt[7] = '{10'h2C0, -49152, -16384};

    // Reset state, with a request pending to show the ROM stays idle.
    in_valid = 1'b1;
    phase_in = 10'h140;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sin", int'(sin_out), 0);
    check("rst_cos", int'(cos_out), 0);
    check("rst_ce0", int'(ce0), 0);
    check("rst_ce1", int'(ce1), 0);
    check("rst_addr0", int'(addr0), 0);
    check("rst_addr1", int'(addr1), 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();

    // Directed table: one beat at a time with latency check.
    for (int v = 0; v < 8; v++) begin
      phase_in = vt[v].ph;
      nxt_s    = vt[v].s;
      nxt_c    = vt[v].c;
      lat_en   = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      drain("table_drain");
    end

    // Back-to-back: 2-cycle latency on consecutive accepts means consecutive results.
    n_out0 = n_out;
    for (int k = 0; k < 8; k++) begin
      set_phase(PW'(k * 131 + 7));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    drain("b2b_drain");
    check("b2b_count", n_out - n_out0, 8);

    // Stream with a 5-cycle output stall.
    lat_en     = 1'b0;
    n_out0     = n_out;
    idx        = 0;
    stall_left = 5;
    for (int c = 0; c < 100; c++) begin
      in_valid = (idx < 8);
      set_phase(PW'((idx % 8) * 97 + 13));
      out_ready = !(c >= 3 && stall_left > 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!out_ready && out_valid) begin
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_ce0", int'(ce0), 0);
        check("stall_ce1", int'(ce1), 0);
        if (sb.size() != 0) begin
          check("stall_sin", int'($signed(sin_out)), sb[0].s);
          check("stall_cos", int'($signed(cos_out)), sb[0].c);
        end
        stall_left--;
      end
      tick();
      if (acc) idx++;
      if (idx == 8 && stall_left == 0 && sb.size() == 0) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("stall_drain");
    check("stall_cycles", stall_left, 0);
    check("stall_count", n_out - n_out0, 8);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    set_phase(10'h0A5);
    in_valid = 1'b1;
    tick();
    set_phase(10'h1A5);
    tick();
    reset    = 1'b1;
    phase_in = 10'h140;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_sin", int'(sin_out), 0);
    check("mid_rst_ce0", int'(ce0), 0);
    check("mid_rst_addr0", int'(addr0), 0);
    sb.delete();
    tick();
    tick();
    in_valid  = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    n_out0 = n_out;
    set_phase(10'h040);
    lat_en   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    drain("post_rst_drain");
    repeat (3) tick();
    check("post_rst_count", n_out - n_out0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
